div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 32, operand/result width.
REQ-002 The block SHALL have parameter DIV_TIMEOUT, default 64, maximum number of BUSY cycles without core_done before abort.
REQ-003 aclk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 aresetn  in  1  reset, synchronous and active-low.
REQ-005 ex_valid  in  1  EX stage holds a DIV/DIVU/MOD/MODU op.
REQ-006 ex_mod  in  1  1 = return remainder, 0 = return quotient.
REQ-007 ex_unsigned  in  1  1 = unsigned op, 0 = signed op.
REQ-008 ex_src1 / ex_src2  in  DW  dividend / divisor.
REQ-009 ex_ready  in  1  downstream accepts the EX result this cycle.
REQ-010 flush  in  1  pipeline flush; kills the in-flight op.
REQ-011 stall  out  1  EX SHALL hold its instruction.
REQ-012 res_valid / res_data  out  1 / DW  result available / result value.
REQ-013 core_start  out  1  one-cycle start pulse to the divider core.
REQ-014 core_signed, core_dividend, core_divisor  out  1, DW, DW  operands to the core, held stable for the whole BUSY state.
REQ-015 core_done, core_quotient, core_remainder  in  1, DW, DW  core completion and results, valid only while core_done=1.
REQ-016 err_timeout  out  1  sticky; set on core timeout.

Function
REQ-017 The FSM SHALL have the states IDLE, BUSY, DONE and DRAIN.
REQ-018 Acceptance: in IDLE with ex_valid=1 and flush=0 the op SHALL be accepted; operands, ex_mod and core_signed=~ex_unsigned SHALL be registered.
REQ-019 Divisor zero, all signedness: accept -> DONE next cycle, no core_start; quotient SHALL be all-ones and remainder SHALL be ex_src1.
REQ-020 Signed, src1=0x80000000 and src2=0xFFFFFFFF: accept -> DONE next cycle, no core_start; quotient SHALL be 0x80000000 and remainder SHALL be 0.
REQ-021 Any other op: accept at cycle T -> BUSY at T+1, with core_start=1 during cycle T+1 only.
REQ-022 core_done SHALL be ignored in the cycle core_start=1; on the first later BUSY cycle with core_done=1, the quotient and remainder SHALL be captured and the FSM SHALL move to DONE.
REQ-023 In DONE, res_valid SHALL be ~flush and res_data SHALL be the captured remainder if ex_mod=1, else the captured quotient.
REQ-024 DONE SHALL persist, with res_data held, until ex_ready=1 or flush=1, then SHALL go to IDLE.
REQ-025 stall SHALL be 1 in these cases: IDLE with ex_valid&~flush; BUSY; DRAIN with ex_valid. It SHALL be 0 otherwise.
REQ-026 Flush in BUSY SHALL go to DRAIN; DRAIN SHALL wait for core_done, discard the result, then go to IDLE.
REQ-027 DRAIN SHALL accept no new op.
REQ-028 Flush in IDLE SHALL accept nothing; flush in DRAIN SHALL have no effect.
REQ-029 A 7-bit busy counter SHALL clear on entry to BUSY/DRAIN and increment each cycle in those states.
REQ-030 When the busy counter reaches DIV_TIMEOUT without core_done: from BUSY the FSM SHALL go to DONE with a result of 0; from DRAIN it SHALL go to IDLE.
REQ-031 On the timeout of REQ-030, err_timeout SHALL be set.
REQ-032 A back-to-back op SHALL be accepted in the IDLE cycle directly following DONE; minimum issue spacing is 2 cycles.

Reset
REQ-033 While aresetn=0 at a clock edge, the FSM SHALL go to IDLE, the counter and captured results SHALL clear, and err_timeout SHALL clear.
REQ-034 While in reset, stall, res_valid, core_start and err_timeout SHALL be 0, res_data and core operands SHALL be 0, and core_signed SHALL be 0.
REQ-035 Reset mid-BUSY SHALL abandon the op; a later stray core_done in IDLE SHALL be ignored.

Verification
REQ-036 Signed DIV 100/-7: core_done 5 cycles after start -> res_valid one cycle after core_done, res_data=0xFFFFFFF2; stall high from acceptance through the core_done cycle.
REQ-037 MODU 7/0 -> no core_start, res_valid at T+1, res_data=7; DIVU 7/0 -> res_data=0xFFFFFFFF.
REQ-038 Signed DIV 0x80000000/0xFFFFFFFF -> res_data=0x80000000 at T+1; the same operands as MOD -> 0.
REQ-039 Flush 2 cycles after start -> stall drops, DRAIN; a new op presented is stalled until core_done; no res_valid for the flushed op.
REQ-040 ex_ready=0 for 3 DONE cycles -> res_valid and res_data stable for 3 cycles; IDLE the cycle after ex_ready=1.
REQ-041 core_done withheld -> after 64 BUSY cycles DONE with res_data=0 and err_timeout=1, sticky until aresetn=0.

Source files
------------

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Sequencer that sits between the EX stage and an iterative divider core.
// It accepts DIV/DIVU/MOD/MODU ops, resolves divide-by-zero and signed
// overflow locally, launches the core for every other op, waits for it (with
// a timeout), and presents the selected quotient/remainder until EX takes it.
// A pipeline flush while the core is running moves the block to DRAIN, where
// the core is allowed to finish and its result is thrown away.
//
// Ports
//   aclk            clock, all state updates on the rising edge
//   aresetn         synchronous active-low reset
//   ex_valid        EX holds a divide/remainder op
//   ex_mod          1 = return remainder, 0 = return quotient
//   ex_unsigned     1 = unsigned op, 0 = signed op
//   ex_src1/2       dividend / divisor
//   ex_ready        downstream accepts the result this cycle
//   flush           kills the in-flight op
//   stall           EX must hold its instruction
//   res_valid/data  result available / result value
//   core_start      one-cycle launch pulse to the core
//   core_signed     signed operation flag to the core
//   core_dividend   dividend to the core (stable through BUSY)
//   core_divisor    divisor to the core (stable through BUSY)
//   core_done       core completion strobe
//   core_quotient   core quotient, valid with core_done
//   core_remainder  core remainder, valid with core_done
//   err_timeout     sticky core-timeout flag
// -----------------------------------------------------------------------------
module div_ctrl #(
   parameter int DW          = 32,
   parameter int DIV_TIMEOUT = 64
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic          ex_valid,
   input  logic          ex_mod,
   input  logic          ex_unsigned,
   input  logic [DW-1:0] ex_src1,
   input  logic [DW-1:0] ex_src2,
   input  logic          ex_ready,
   input  logic          flush,
   output logic          stall,
   output logic          res_valid,
   output logic [DW-1:0] res_data,
   output logic          core_start,
   output logic          core_signed,
   output logic [DW-1:0] core_dividend,
   output logic [DW-1:0] core_divisor,
   input  logic          core_done,
   input  logic [DW-1:0] core_quotient,
   input  logic [DW-1:0] core_remainder,
   output logic          err_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DONE  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};
   localparam logic [DW-1:0] ZERO     = {DW{1'b0}};
   localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
   // The busy counter holds the number of completed cycles in BUSY/DRAIN,
   // so the last permitted cycle is the one where it equals DIV_TIMEOUT-1.
   localparam logic [6:0]    CNT_LAST = 7'(DIV_TIMEOUT - 1);

   // Signed most-negative / -1 overflows; it is answered without the core.
   function automatic logic f_signed_ovf(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b,
                                         input logic          is_signed);
      return is_signed & (a == MIN_NEG) & (b == ALL_ONES);
   endfunction

   function automatic logic f_div_zero(input logic [DW-1:0] b);
      return (b == ZERO);
   endfunction

   state_t        r_state;
   state_t        w_state_nxt;
   logic [DW-1:0] r_src1;
   logic [DW-1:0] r_src2;
   logic          r_mod;
   logic          r_signed;
   logic [DW-1:0] r_quot;
   logic [DW-1:0] r_rem;
   logic [6:0]    r_cnt;
   logic          r_start;
   logic          r_err;

   logic          w_accept;
   logic          w_zero_div;
   logic          w_ovf;
   logic          w_special;
   logic          w_core_ok;
   logic          w_cnt_last;
   logic          w_capture;
   logic          w_zero_res;
   logic          w_set_err;
   logic          w_stall;
   logic          w_res_valid;
   logic [DW-1:0] w_res_data;

   assign w_accept   = (r_state == ST_IDLE) & ex_valid & ~flush;
   assign w_zero_div = f_div_zero(ex_src2);
   assign w_ovf      = f_signed_ovf(ex_src1, ex_src2, ~ex_unsigned);
   assign w_special  = w_zero_div | w_ovf;
   // A done strobe coinciding with the launch pulse belongs to no op of ours.
   assign w_core_ok  = core_done & ~r_start;
   assign w_cnt_last = (r_cnt == CNT_LAST);

   // Next-state decode plus datapath control and EX handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_zero_res  = 1'b0;
      w_set_err   = 1'b0;
      w_stall     = 1'b0;
      w_res_valid = 1'b0;
      w_res_data  = ZERO;
      case (r_state)
         ST_IDLE: begin
            w_stall = ex_valid & ~flush;
            if (w_accept) begin
               if (w_special) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_BUSY;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            w_stall = 1'b1;
            if (flush) begin
               // If the core finishes in the flush cycle there is nothing
               // left to drain, so return straight to IDLE.
               if (w_core_ok) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end else if (w_core_ok) begin
               w_state_nxt = ST_DONE;
               w_capture   = 1'b1;
            end else if (w_cnt_last) begin
               w_state_nxt = ST_DONE;
               w_zero_res  = 1'b1;
               w_set_err   = 1'b1;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_DONE: begin
            w_res_valid = ~flush;
            w_res_data  = r_mod ? r_rem : r_quot;
            if (ex_ready | flush) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DRAIN: begin
            w_stall = ex_valid;
            if (core_done) begin
               w_state_nxt = ST_IDLE;
            end else if (w_cnt_last) begin
               w_state_nxt = ST_IDLE;
               w_set_err   = 1'b1;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture at acceptance; held unchanged through BUSY.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_src1   <= ZERO;
         r_src2   <= ZERO;
         r_mod    <= 1'b0;
         r_signed <= 1'b0;
      end else if (w_accept) begin
         r_src1   <= ex_src1;
         r_src2   <= ex_src2;
         r_mod    <= ex_mod;
         r_signed <= ~ex_unsigned;
      end else begin
         r_src1   <= r_src1;
         r_src2   <= r_src2;
         r_mod    <= r_mod;
         r_signed <= r_signed;
      end
   end

   // Result capture: locally resolved cases, core results, or timeout zero.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_quot <= ZERO;
         r_rem  <= ZERO;
      end else if (w_accept & w_zero_div) begin
         r_quot <= ALL_ONES;
         r_rem  <= ex_src1;
      end else if (w_accept & w_ovf) begin
         r_quot <= MIN_NEG;
         r_rem  <= ZERO;
      end else if (w_capture) begin
         r_quot <= core_quotient;
         r_rem  <= core_remainder;
      end else if (w_zero_res) begin
         r_quot <= ZERO;
         r_rem  <= ZERO;
      end else begin
         r_quot <= r_quot;
         r_rem  <= r_rem;
      end
   end

   // Launch pulse: high only in the first BUSY cycle.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_start <= 1'b0;
      end else begin
         r_start <= (r_state == ST_IDLE) & (w_state_nxt == ST_BUSY);
      end
   end

   // Busy counter: restarts on any state change, counts while BUSY/DRAIN.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_cnt <= 7'd0;
      end else if (w_state_nxt != r_state) begin
         r_cnt <= 7'd0;
      end else if ((r_state == ST_BUSY) || (r_state == ST_DRAIN)) begin
         r_cnt <= r_cnt + 7'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_err <= 1'b0;
      end else if (w_set_err) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

   // Output drive; everything reads zero while reset is asserted, even
   // before the first clock edge has cleared the registers.
   always_comb begin
      stall         = 1'b0;
      res_valid     = 1'b0;
      res_data      = ZERO;
      core_start    = 1'b0;
      core_signed   = 1'b0;
      core_dividend = ZERO;
      core_divisor  = ZERO;
      err_timeout   = 1'b0;
      if (aresetn) begin
         stall         = w_stall;
         res_valid     = w_res_valid;
         res_data      = w_res_data;
         core_start    = r_start;
         core_signed   = r_signed;
         core_dividend = r_src1;
         core_divisor  = r_src2;
         err_timeout   = r_err;
      end else begin
         stall         = 1'b0;
         res_valid     = 1'b0;
         res_data      = ZERO;
         core_start    = 1'b0;
         core_signed   = 1'b0;
         core_dividend = ZERO;
         core_divisor  = ZERO;
         err_timeout   = 1'b0;
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl. A behavioural divider core answers
// core_start after a programmable latency. Stimulus pushes the expected
// result of every op into a scoreboard queue and the expected core operands
// into a second queue; a monitor compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_div_ctrl;
   localparam int DW = 32;
   localparam int TO = 64;
   localparam logic [DW-1:0] ONES = 32'hFFFF_FFFF;
   localparam logic [DW-1:0] MINV = 32'h8000_0000;
   localparam logic [DW-1:0] ZERO = 32'h0000_0000;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          ex_valid;
   logic          ex_mod;
   logic          ex_unsigned;
   logic [DW-1:0] ex_src1;
   logic [DW-1:0] ex_src2;
   logic          ex_ready;
   logic          flush;
   logic          stall;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          core_start;
   logic          core_signed;
   logic [DW-1:0] core_dividend;
   logic [DW-1:0] core_divisor;
   logic          core_done;
   logic [DW-1:0] core_quotient;
   logic [DW-1:0] core_remainder;
   logic          err_timeout;

   always #5 aclk = ~aclk;

   div_ctrl #(.DW(DW), .DIV_TIMEOUT(TO)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .ex_valid      (ex_valid),
      .ex_mod        (ex_mod),
      .ex_unsigned   (ex_unsigned),
      .ex_src1       (ex_src1),
      .ex_src2       (ex_src2),
      .ex_ready      (ex_ready),
      .flush         (flush),
      .stall         (stall),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .core_start    (core_start),
      .core_signed   (core_signed),
      .core_dividend (core_dividend),
      .core_divisor  (core_divisor),
      .core_done     (core_done),
      .core_quotient (core_quotient),
      .core_remainder(core_remainder),
      .err_timeout   (err_timeout)
   );

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_q[$];
   logic [2*DW:0] start_q[$];
   int            core_lat  = 4;
   bit            core_hold = 1'b0;
   bit            stray_req = 1'b0;

   // Architectural divide/remainder result.
   function automatic logic [DW-1:0] ref_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic u, input logic m);
      logic signed [DW-1:0] sa;
      logic signed [DW-1:0] sb;
      logic signed [DW-1:0] rs;
      if (b == ZERO) return m ? a : ONES;
      if (!u && a == MINV && b == ONES) return m ? ZERO : MINV;
      if (u) return m ? (a % b) : (a / b);
      sa = a;
      sb = b;
      rs = m ? (sa % sb) : (sa / sb);
      return rs;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural divider core.
   initial begin : core_model
      bit pend;
      int cnt;
      pend = 1'b0;
      cnt  = 0;
      core_done      = 1'b0;
      core_quotient  = ZERO;
      core_remainder = ZERO;
      forever begin
         @(posedge aclk);
         #2;
         core_done      = 1'b0;
         core_quotient  = $urandom;
         core_remainder = $urandom;
         if (aresetn !== 1'b1) begin
            pend = 1'b0;
         end else if (stray_req) begin
            core_done = 1'b1;
         end else if (core_start === 1'b1) begin
            core_done = 1'($urandom_range(0, 1));
            pend = !core_hold;
            cnt  = core_lat;
         end else if (pend) begin
            cnt--;
            if (cnt <= 0) begin
               pend           = 1'b0;
               core_done      = 1'b1;
               core_quotient  = ref_res(core_dividend, core_divisor, !core_signed, 1'b0);
               core_remainder = ref_res(core_dividend, core_divisor, !core_signed, 1'b1);
            end
         end
      end
   end

   // Scoreboard monitor.
   initial begin : monitor
      logic [2*DW:0] s;
      forever begin
         @(negedge aclk);
         if (aresetn === 1'b1) begin
            if (res_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL spurious_res_valid: got res_data %0h expected no result at %0t", res_data, $time);
               end else begin
                  chk("res_data", 64'(res_data), 64'(exp_q[0]));
                  if (ex_ready === 1'b1) void'(exp_q.pop_front());
               end
            end
            if (core_start === 1'b1) begin
               if (start_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL spurious_core_start: got 1 expected 0 at %0t", $time);
               end else begin
                  s = start_q.pop_front();
                  chk("core_signed",   64'(core_signed),   64'(s[2*DW]));
                  chk("core_dividend", 64'(core_dividend), 64'(s[2*DW-1:DW]));
                  chk("core_divisor",  64'(core_divisor),  64'(s[DW-1:0]));
               end
            end
         end
      end
   end

   // Issue one op, hold it until the result handshake, and check timing.
   task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic u,
                         input logic m, input int lat, input int hold);
      bit            special;
      int            exp_lat;
      int            n_done;
      int            first_rv;
      bit            fin;
      logic [DW-1:0] exp_v;
      special = (b == ZERO) || (!u && a == MINV && b == ONES);
      exp_lat = special ? 1 : (core_hold ? TO + 1 : lat + 2);
      exp_v   = (core_hold && !special) ? ZERO : ref_res(a, b, u, m);
      exp_q.push_back(exp_v);
      if (!special) start_q.push_back({~u, a, b});
      core_lat    = lat;
      ex_valid    = 1'b1;
      ex_src1     = a;
      ex_src2     = b;
      ex_unsigned = u;
      ex_mod      = m;
      n_done   = 0;
      first_rv = -1;
      fin      = 1'b0;
      for (int c = 0; c < TO + 40 && !fin; c++) begin
         ex_ready = (n_done >= hold);
         @(negedge aclk);
         chk("stall", 64'(stall), 64'(c < exp_lat));
         if (res_valid === 1'b1) begin
            if (first_rv < 0) first_rv = c;
            if (ex_ready) fin = 1'b1;
            n_done++;
         end
         @(posedge aclk);
         #1;
      end
      if (!fin) begin
         n_vec++;
         n_err++;
         $display("FAIL op_handshake: got no handshake within %0d cycles expected one", TO + 40);
      end
      chk("result_latency", 64'(first_rv), 64'(exp_lat));
      ex_valid = 1'b0;
      ex_ready = 1'b0;
   endtask

   // Main stimulus.
   initial begin : stim
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          u;
      logic          m;
      int            sel;
      aresetn = 1'b0; ex_valid = 1'b1; ex_mod = 1'b0; ex_unsigned = 1'b0;
      ex_src1 = 32'd1234; ex_src2 = 32'd5; ex_ready = 1'b1; flush = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("rst_stall",     64'(stall),         64'd0);
      chk("rst_res_valid", 64'(res_valid),     64'd0);
      chk("rst_res_data",  64'(res_data),      64'd0);
      chk("rst_core_start",64'(core_start),    64'd0);
      chk("rst_core_sgn",  64'(core_signed),   64'd0);
      chk("rst_core_dvd",  64'(core_dividend), 64'd0);
      chk("rst_core_dvs",  64'(core_divisor),  64'd0);
      chk("rst_err",       64'(err_timeout),   64'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1; ex_valid = 1'b0; ex_ready = 1'b0;
      @(posedge aclk); #1;

      // Directed ops: signed DIV 100/-7, zero divisors, overflow, held result.
      run_op(32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0, 5, 0);
      run_op(32'd7, ZERO, 1'b1, 1'b1, 3, 0);
      run_op(32'd7, ZERO, 1'b1, 1'b0, 3, 0);
      run_op(32'hFFFF_FFFB, ZERO, 1'b0, 1'b1, 3, 0);
      run_op(MINV, ONES, 1'b0, 1'b0, 3, 0);
      run_op(MINV, ONES, 1'b0, 1'b1, 3, 0);
      run_op(MINV, ONES, 1'b1, 1'b0, 2, 0);
      run_op(32'd1000, 32'd7, 1'b1, 1'b1, 4, 3);
      run_op(32'hFFFF_FC18, 32'd7, 1'b0, 1'b1, 1, 0);

      // Flush in IDLE accepts nothing.
      ex_valid = 1'b1; ex_src1 = 32'd5; ex_src2 = 32'd1; ex_unsigned = 1'b1; flush = 1'b1;
      @(negedge aclk);
      chk("idle_flush_stall", 64'(stall), 64'd0);
      @(posedge aclk); #1;
      ex_valid = 1'b0; flush = 1'b0;
      @(negedge aclk);
      chk("idle_flush_res_valid", 64'(res_valid), 64'd0);
      @(posedge aclk); #1;

      // Flush while a result waits in DONE.
      ex_valid = 1'b1; ex_unsigned = 1'b1; ex_mod = 1'b0; ex_src1 = 32'd9; ex_src2 = ZERO;
      @(posedge aclk); #1;
      flush = 1'b1;
      @(negedge aclk);
      chk("done_flush_res_valid", 64'(res_valid), 64'd0);
      chk("done_flush_stall", 64'(stall), 64'd0);
      @(posedge aclk); #1;
      flush = 1'b0; ex_valid = 1'b0;
      @(negedge aclk);
      chk("after_flush_res_valid", 64'(res_valid), 64'd0);
      @(posedge aclk); #1;

      // Flush two cycles after start, then a new op waits out the drain.
      core_lat = 6;
      ex_valid = 1'b1; ex_unsigned = 1'b0; ex_mod = 1'b0; ex_src1 = 32'd500; ex_src2 = 32'd3;
      start_q.push_back({1'b1, 32'd500, 32'd3});
      repeat (3) begin
         @(posedge aclk); #1;
      end
      flush = 1'b1;
      @(posedge aclk); #1;
      flush = 1'b0; ex_valid = 1'b0;
      @(negedge aclk);
      chk("drain_stall_idle", 64'(stall), 64'd0);
      @(posedge aclk); #1;
      ex_valid = 1'b1; ex_unsigned = 1'b1; ex_mod = 1'b1; ex_src1 = 32'd77; ex_src2 = 32'd10;
      repeat (3) begin
         @(negedge aclk);
         chk("drain_stall_new", 64'(stall), 64'd1);
         @(posedge aclk); #1;
      end
      run_op(32'd77, 32'd10, 1'b1, 1'b1, 3, 0);

      // Randomized ops, back to back.
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 9);
         a = $urandom;
         b = $urandom;
         if (sel == 0) begin
            b = ZERO;
         end else if (sel == 1) begin
            a = MINV;
            b = ONES;
         end else if (sel < 5) begin
            b = DW'($urandom_range(1, 20));
            if (sel == 4) b = -b;
         end
         u = 1'($urandom_range(0, 1));
         m = 1'($urandom_range(0, 1));
         run_op(a, b, u, m, $urandom_range(1, 8), $urandom_range(0, 2));
      end
      @(negedge aclk);
      chk("err_before_timeout", 64'(err_timeout), 64'd0);
      @(posedge aclk); #1;

      // Core never answers: timeout gives zero and sets the sticky flag.
      core_hold = 1'b1;
      run_op(32'd50, 32'd3, 1'b1, 1'b0, 5, 0);
      core_hold = 1'b0;
      @(negedge aclk);
      chk("err_after_timeout", 64'(err_timeout), 64'd1);
      @(posedge aclk); #1;
      run_op(32'd81, 32'd9, 1'b0, 1'b0, 2, 1);
      @(negedge aclk);
      chk("err_sticky", 64'(err_timeout), 64'd1);
      @(posedge aclk); #1;

      // Reset in the middle of BUSY, then a stray core_done in IDLE.
      core_lat = 20;
      ex_valid = 1'b1; ex_unsigned = 1'b1; ex_mod = 1'b0; ex_src1 = 32'd900; ex_src2 = 32'd4;
      start_q.push_back({1'b0, 32'd900, 32'd4});
      repeat (3) begin
         @(posedge aclk); #1;
      end
      aresetn = 1'b0;
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("midrst_stall", 64'(stall), 64'd0);
      chk("midrst_err",   64'(err_timeout), 64'd0);
      chk("midrst_dvd",   64'(core_dividend), 64'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1; ex_valid = 1'b0;
      @(posedge aclk); #1;
      stray_req = 1'b1;
      @(negedge aclk);
      chk("stray_stall", 64'(stall), 64'd0);
      @(posedge aclk); #1;
      stray_req = 1'b0;
      @(negedge aclk);
      chk("stray_res_valid", 64'(res_valid), 64'd0);
      chk("stray_err", 64'(err_timeout), 64'd0);
      @(posedge aclk); #1;
      run_op(32'd100, 32'hFFFF_FFF9, 1'b0, 1'b1, 4, 0);

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("results_outstanding", 64'(exp_q.size()), 64'd0);
      chk("starts_outstanding", 64'(start_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
